// File: rtl/wb_uart_rx.sv
// wb_uart_rx: 8N1 UART receiver with a single-entry byte buffer read over a
// Wishbone B4 pipelined port. Flags framing errors (pulse) and overruns (sticky).
module wb_uart_rx #(
  parameter int unsigned TICKS_PER_BAUD = 8
) (
  input  logic       i_wb_clk,
  input  logic       i_wb_rst,
  input  logic       i_uart_rx,
  input  logic       i_wb_stb,
  output logic       o_wb_stall,
  output logic       o_wb_ack,
  output logic [7:0] o_wb_data,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam logic [7:0] HALF_M1 = 8'(TICKS_PER_BAUD / 2 - 1);
  localparam logic [7:0] FULL_M1 = 8'(TICKS_PER_BAUD - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t     state, state_n;
  logic       rx_meta, rx_s;
  logic [7:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [7:0] shreg, shreg_n;
  logic       byte_done;
  logic       frame_err_n;

  logic [7:0] buf_data;
  logic       valid;
  logic       ack;
  logic [7:0] rd_data;
  logic       frame_err;
  logic       overrun;
  logic       rd_accept;

  assign rd_accept   = i_wb_stb && valid;
  assign o_wb_stall  = !valid;
  assign o_wb_ack    = ack;
  assign o_wb_data   = rd_data;
  assign o_frame_err = frame_err;
  assign o_overrun   = overrun;

  // Two-flop synchronizer for the asynchronous serial input; idles high.
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_uart_rx;
      rx_s    <= rx_meta;
    end
  end

  // Receiver state register with its baud counter, bit index and shifter.
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
    end
  end

  // Next-state logic: mid-bit start check, full-bit data/stop sampling.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bit_idx_n   = bit_idx;
    shreg_n     = shreg;
    byte_done   = 1'b0;
    frame_err_n = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_n = '0;
          if (rx_s) begin
            state_n = IDLE;
          end else begin
            state_n   = DATA;
            bit_idx_n = '0;
          end
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          cnt_n   = '0;
          shreg_n = {rx_s, shreg[7:1]};
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_idx_n = bit_idx + 3'd1;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      STOP: begin
        if (cnt == FULL_M1) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (rx_s) byte_done   = 1'b1;
          else      frame_err_n = 1'b1;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Byte buffer, Wishbone read response and status flags.
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      buf_data  <= '0;
      valid     <= 1'b0;
      ack       <= 1'b0;
      rd_data   <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      ack       <= rd_accept;
      rd_data   <= rd_accept ? buf_data : '0;
      frame_err <= frame_err_n;
      if (rd_accept) begin
        // A byte landing in the read cycle refills the buffer; nothing is lost.
        overrun <= 1'b0;
        if (byte_done) buf_data <= shreg;
        else           valid    <= 1'b0;
      end else if (byte_done) begin
        if (valid) begin
          overrun <= 1'b1;
        end else begin
          buf_data <= shreg;
          valid    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_uart_rx.sv
// tb_wb_uart_rx: table-driven frames plus hand-written corner sequences for
// wb_uart_rx; read data is checked against a queue of expected bytes.
module tb_wb_uart_rx;

  localparam int unsigned T = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_pin = 1'b1;
  logic       stb = 1'b0;
  logic       stall, ack, frame_err, overrun;
  logic [7:0] data;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic [7:0] byte_v;
    logic       stop_bit;
    int         exp_fe;
  } vec_t;

  vec_t vecs[6];

  wb_uart_rx #(.TICKS_PER_BAUD(T)) dut (
    .i_wb_clk   (clk),
    .i_wb_rst   (rst),
    .i_uart_rx  (uart_pin),
    .i_wb_stb   (stb),
    .o_wb_stall (stall),
    .o_wb_ack   (ack),
    .o_wb_data  (data),
    .o_frame_err(frame_err),
    .o_overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pop on every ack, idle data must be zero, count error pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) fe_cnt++;
      checks++;
      if (ack) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL ack_unexpected: got data %h with empty scoreboard", data);
        end else begin
          logic [7:0] e;
          e = sb.pop_front();
          if (data !== e) begin
            errors++;
            $display("FAIL ack_data: got %h expected %h", data, e);
          end
        end
      end else if (data !== 8'h00) begin
        errors++;
        $display("FAIL idle_data: got %h expected 00", data);
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    uart_pin = 1'b0;
    repeat (T) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_pin = b[i];
      repeat (T) @(negedge clk);
    end
    uart_pin = stop_bit;
    repeat (T) @(negedge clk);
    uart_pin = 1'b1;
  endtask

  task automatic do_read(input string name);
    int n;
    n = 0;
    while (stall && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (stall) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: stall still 1 after %0d cycles, required 0", name, n);
    end else begin
      stb = 1'b1;
      @(negedge clk);
      stb = 1'b0;
      check({name, "_ack"}, {7'd0, ack}, 8'd1);
    end
  endtask

  task automatic idle(input int unsigned bits);
    repeat (bits * T) @(negedge clk);
  endtask

  initial begin
    int fe0;
    vecs[0] = '{8'hA5, 1'b1, 0};
    vecs[1] = '{8'h55, 1'b0, 1};
    vecs[2] = '{8'h0F, 1'b1, 0};
    vecs[3] = '{8'h00, 1'b1, 0};
    vecs[4] = '{8'hFF, 1'b1, 0};
    vecs[5] = '{8'h80, 1'b1, 0};

    repeat (3) @(negedge clk);
    check("rst_stall", {7'd0, stall}, 8'd1);
    check("rst_ack", {7'd0, ack}, 8'd0);
    check("rst_data", data, 8'h00);
    check("rst_fe", {7'd0, frame_err}, 8'd0);
    check("rst_ovr", {7'd0, overrun}, 8'd0);
    rst = 1'b0;
    idle(2);

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      fe0 = fe_cnt;
      send_frame(vecs[v].byte_v, vecs[v].stop_bit);
      idle(2);
      check($sformatf("vec%0d_fe", v), 8'(fe_cnt - fe0), 8'(vecs[v].exp_fe));
      check($sformatf("vec%0d_stall", v), {7'd0, stall}, {7'd0, ~vecs[v].stop_bit});
      if (vecs[v].stop_bit) begin
        sb.push_back(vecs[v].byte_v);
        do_read($sformatf("vec%0d_rd", v));
        check($sformatf("vec%0d_stall_after", v), {7'd0, stall}, 8'd1);
      end
    end

    // Glitch rejection, then a strobe while stalled
    fe0 = fe_cnt;
    uart_pin = 1'b0;
    repeat (2) @(negedge clk);
    uart_pin = 1'b1;
    idle(3);
    check("glitch_stall", {7'd0, stall}, 8'd1);
    check("glitch_fe", 8'(fe_cnt - fe0), 8'd0);
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    check("stalled_stb_ack", {7'd0, ack}, 8'd0);
    send_frame(8'h3C, 1'b1);
    idle(2);
    sb.push_back(8'h3C);
    do_read("glitch_3c");

    // Overrun: second byte dropped, read returns the first
    send_frame(8'h11, 1'b1);
    sb.push_back(8'h11);
    idle(1);
    send_frame(8'h22, 1'b1);
    idle(1);
    check("ovr_set", {7'd0, overrun}, 8'd1);
    do_read("ovr_rd");
    check("ovr_clr", {7'd0, overrun}, 8'd0);
    check("ovr_stall", {7'd0, stall}, 8'd1);
    idle(1);

    // Read accepted in the exact cycle the next byte completes
    send_frame(8'h11, 1'b1);
    sb.push_back(8'h11);
    idle(2);
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (78) @(negedge clk);
        stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
        check("sim_ack", {7'd0, ack}, 8'd1);
        check("sim_stall", {7'd0, stall}, 8'd0);
        check("sim_ovr", {7'd0, overrun}, 8'd0);
      end
    join
    sb.push_back(8'h22);
    do_read("sim_second");
    idle(1);

    // Reset mid-frame with a buffered byte and overrun pending
    send_frame(8'h42, 1'b1);
    idle(1);
    send_frame(8'h43, 1'b1);
    idle(1);
    check("pre_rst_ovr", {7'd0, overrun}, 8'd1);
    check("pre_rst_stall", {7'd0, stall}, 8'd0);
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (5 * T + 4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_stall", {7'd0, stall}, 8'd1);
        check("mid_rst_ovr", {7'd0, overrun}, 8'd0);
        check("mid_rst_ack", {7'd0, ack}, 8'd0);
        check("mid_rst_data", data, 8'h00);
        check("mid_rst_fe", {7'd0, frame_err}, 8'd0);
        sb.delete();
      end
    join
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    check("post_rst_stall", {7'd0, stall}, 8'd1);
    send_frame(8'h81, 1'b1);
    idle(1);
    sb.push_back(8'h81);
    do_read("post_rst_81");

    idle(2);
    check("sb_empty", 8'(sb.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
